swap_sequencer: RTL
===================

# swap_sequencer

Controller in front of `Register_Mapper` that owns its `doSWAP` port. Accepts SWAP requests from decode through a valid/ready queue and issues them to the mapper one per cycle, with a pipeline stall. Keeps a shadow copy of the mapping table so it can report whether the mapping is identity. Can also issue a minimal sequence of corrective swaps that returns the mapping to identity without a global reset.

## Interface
- `DEPTH`, default 4: request queue entries; a power of two, at least 2.
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `stall` in 1: when high, no swap is issued this cycle.
- `req_valid` in 1: a swap request is presented.
- `req_a` in 2: first register index.
- `req_b` in 2: second register index.
- `req_ready` out 1: the queue accepts a request this cycle.
- `restore_req` in 1: single-cycle pulse that starts a return to identity.
- `restore_busy` out 1: a restore is in progress (DRAIN or RESTORE state).
- `restore_done` out 1: one-cycle pulse when a restore completes.
- `swap_en` out 1: registered; drives `doSWAP`.
- `swap_r1` out 2: registered; first mapper index.
- `swap_r2` out 2: registered; second mapper index.
- `identity` out 1: the shadow map is {0,1,2,3}.
- `q_count` out $clog2(DEPTH)+1: current queue occupancy.

## Operation
- **Enqueue:** a request is accepted at a clock edge when `req_valid && req_ready`.
  - `req_ready = !full && state==IDLE`.
  - Requests with `req_a==req_b` are enqueued and issued like any other; the shadow map does not change.
- **Issue:** an entry is popped at an edge when the queue is non-empty, `!stall`, and the state is IDLE or DRAIN. At that edge:
  - `swap_en<=1`, `swap_r1<=head.a`, `swap_r2<=head.b`.
  - The shadow map performs `m[a]<=m[b]`, `m[b]<=m[a]`.
  - At every other edge `swap_en<=0`. The indices hold their last value.
- **Shadow map:** after each issue the shadow map equals the mapper state the mapper will hold one edge later.
- **States:** the FSM has three states.
  - IDLE: on `restore_req`, go to DRAIN.
  - DRAIN: issue queue entries; when the queue is empty, go to RESTORE.
  - RESTORE: each `!stall` edge, take the lowest i with m[i]!=i and the j with m[j]==i, and issue swap(i,j). This sets m[i]=i. When `identity` is high, go to IDLE and pulse `restore_done`.
- **Restore bounds:** a restore issues at most 3 corrective swaps. Restore from identity issues none; DRAIN→RESTORE→IDLE then pulses `restore_done`.
- **Ignored restore:** `restore_req` while `restore_busy` is ignored.
- **Simultaneous events:**
  - `restore_req` and an accepted request on the same edge: the request is enqueued, and it is drained before the restore.
  - A push and a pop on the same edge: the count is unchanged.
  - A full queue never accepts, even when a pop occurs on the same edge.

## Timing
- **Reset values** (asynchronous):
  - `swap_en=0`, `swap_r1=0`, `swap_r2=0`.
  - Shadow map = identity, so `identity=1`.
  - Queue empty, `q_count=0`, `req_ready=1`.
  - State IDLE, `restore_busy=0`, `restore_done=0`.
- **Reset mid-operation:** reset during a restore or with the queue non-empty discards everything. The mapper shares `reset`, so the two stay consistent.
- **Latency:** with the queue empty and no stall, a request accepted at edge N gives `swap_en` high in the cycle after edge N+1. The mapper updates at edge N+2.
- **Throughput:** one swap per cycle. `stall` freezes pops without dropping entries.
- **Combinational outputs:** `req_ready` and `identity` are combinational from registered state. `restore_done` is registered.

## Configuration
- `SWAP_RESTORE_EN`
  - Defined: the DRAIN/RESTORE logic and `restore_req` are active.
  - Undefined: `restore_req` is ignored, and `restore_busy` and `restore_done` are tied to 0. The FSM reduces to IDLE. `identity` and the shadow map remain.

## Structure
- **Package `swap_pkg`:**
  - `reg_idx_t` (logic [1:0]), `NUM_REGS=4`.
  - `swap_req_t` struct {a, b}.
  - `seq_state_t` enum {IDLE, DRAIN, RESTORE}.
- **Sub-module `swap_fifo`:** a parameterized synchronous FIFO of `swap_req_t` with push, pop, full, empty and count.

## Test plan
- Reset → `req_ready=1`, `swap_en=0`, `identity=1`, `q_count=0`.
- Push (0,1), stall=0 → exactly one `swap_en` pulse with r1=0, r2=1 in the cycle after the second edge; `identity=0`.
- stall=1, push 4 requests → 5th sees `req_ready=0`. Drop stall → 4 consecutive pulses in FIFO order; `q_count` goes 4→0.
- Swaps (0,1),(1,2), then `restore_req` → shadow [1,2,0,3]; RESTORE issues (0,2) then (1,2); `restore_done` pulses; `identity=1`.
- Assert reset in the first RESTORE cycle → immediately `swap_en=0`, `restore_busy=0`, `identity=1`; after release the controller accepts requests.
- Push (2,2) → one pulse with r1=r2=2; `identity` stays 1. Without `SWAP_RESTORE_EN`, `restore_req` → `restore_busy` stays 0.

Source files
------------

// File: rtl/swap_pkg.sv
// swap_pkg: shared types and helpers for the swap sequencer.
//   reg_idx_t   : 2-bit mapper register index
//   swap_req_t  : one swap request {a, b}
//   seq_state_t : sequencer FSM states
//   map_t       : packed shadow mapping table, entry i holds m[i]
package swap_pkg;

    localparam int NUM_REGS = 4;

    typedef logic [1:0] reg_idx_t;

    typedef struct packed {
        reg_idx_t a;
        reg_idx_t b;
    } swap_req_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRAIN   = 2'd1,
        RESTORE = 2'd2
    } seq_state_t;

    typedef logic [NUM_REGS-1:0][1:0] map_t;

    localparam map_t IDENTITY_MAP = {2'd3, 2'd2, 2'd1, 2'd0};

    // True when every entry maps to itself.
    function automatic logic map_is_identity(input map_t m);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (m[i] != reg_idx_t'(i)) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

    // Corrective swap: lowest i with m[i]!=i, paired with the j holding i.
    // Scanning downwards lets the lowest mismatching index win.
    function automatic swap_req_t restore_step(input map_t m);
        swap_req_t s;
        s.a = 2'd0;
        s.b = 2'd0;
        for (int i = NUM_REGS - 1; i >= 0; i--) begin
            if (m[i] != reg_idx_t'(i)) begin
                s.a = reg_idx_t'(i);
            end
        end
        for (int j = 0; j < NUM_REGS; j++) begin
            if (m[j] == s.a) begin
                s.b = reg_idx_t'(j);
            end
        end
        return s;
    endfunction

endpackage

// File: rtl/swap_fifo.sv
// swap_fifo: synchronous FIFO of swap_req_t.
// Ports: clk, reset (async, active-high), i_push/i_pop (ignored when
// full/empty respectively), din, dout (head, combinational), full, empty,
// count (occupancy, $clog2(DEPTH)+1 bits).
module swap_fifo
    import swap_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  swap_req_t                i_din,
    output swap_req_t                o_dout,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    swap_req_t         r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic              w_push;
    logic              w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == CW'(0));
    assign o_count = r_count;
    assign o_dout  = r_mem[r_rd_ptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    // Entry storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    // Pointers and occupancy; a simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= AW'(0);
            r_rd_ptr <= AW'(0);
            r_count  <= CW'(0);
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/swap_sequencer.sv
// swap_sequencer: owns the Register_Mapper doSWAP port.
// Queues swap requests (valid/ready), issues one per non-stalled cycle,
// keeps a shadow of the mapping table and reports whether it is identity.
// With SWAP_RESTORE_EN defined, restore_req drains the queue and then issues
// the minimal corrective swaps back to identity; otherwise restore_req is
// ignored and restore_busy/restore_done are held low.
// Ports: clk, reset (async, active-high), stall, req_valid/req_a/req_b/
// req_ready (request queue), restore_req/restore_busy/restore_done,
// swap_en/swap_r1/swap_r2 (registered mapper drive), identity, q_count.
module swap_sequencer
    import swap_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    stall,
    input  logic                    req_valid,
    input  logic [1:0]              req_a,
    input  logic [1:0]              req_b,
    output logic                    req_ready,
    input  logic                    restore_req,
    output logic                    restore_busy,
    output logic                    restore_done,
    output logic                    swap_en,
    output logic [1:0]              swap_r1,
    output logic [1:0]              swap_r2,
    output logic                    identity,
    output logic [$clog2(DEPTH):0]  q_count
);

    logic       r_swap_en;
    reg_idx_t   r_swap_r1;
    reg_idx_t   r_swap_r2;
    map_t       r_map;

    logic       w_push;
    logic       w_pop;
    logic       w_full;
    logic       w_empty;
    logic       w_idle;
    logic       w_drain;
    logic       w_fix_issue;
    logic       w_issue;
    swap_req_t  w_head;
    swap_req_t  w_req;
    swap_req_t  w_sel;

    assign w_req.a = req_a;
    assign w_req.b = req_b;

    swap_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (w_req),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (q_count)
    );

`ifdef SWAP_RESTORE_EN
    seq_state_t r_state;
    logic       r_restore_done;
    swap_req_t  w_fix;

    assign w_idle       = (r_state == IDLE);
    assign w_drain      = (r_state == DRAIN);
    assign w_fix        = restore_step(r_map);
    assign w_fix_issue  = (r_state == RESTORE) && !identity && !stall;
    assign w_sel        = w_pop ? w_head : w_fix;
    assign restore_busy = !w_idle;
    assign restore_done = r_restore_done;

    // Restore FSM: IDLE -> DRAIN (empty queue) -> RESTORE (until identity) -> IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= IDLE;
            r_restore_done <= 1'b0;
        end else begin
            r_restore_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (restore_req) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (w_empty) begin
                        r_state <= RESTORE;
                    end
                end
                RESTORE: begin
                    if (identity) begin
                        r_state        <= IDLE;
                        r_restore_done <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
`else
    logic w_unused_restore;

    assign w_unused_restore = restore_req;
    assign w_idle       = 1'b1;
    assign w_drain      = 1'b0;
    assign w_fix_issue  = 1'b0;
    assign w_sel        = w_head;
    assign restore_busy = 1'b0;
    assign restore_done = 1'b0;
`endif

    assign req_ready = !w_full && w_idle;
    assign w_push    = req_valid && req_ready;
    assign w_pop     = !w_empty && !stall && (w_idle || w_drain);
    assign w_issue   = w_pop || w_fix_issue;
    assign identity  = map_is_identity(r_map);

    assign swap_en = r_swap_en;
    assign swap_r1 = r_swap_r1;
    assign swap_r2 = r_swap_r2;

    // Mapper drive and shadow map; the shadow runs one edge ahead of the mapper.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_swap_en <= 1'b0;
            r_swap_r1 <= 2'd0;
            r_swap_r2 <= 2'd0;
            r_map     <= IDENTITY_MAP;
        end else begin
            r_swap_en <= w_issue;
            if (w_issue) begin
                r_swap_r1        <= w_sel.a;
                r_swap_r2        <= w_sel.b;
                r_map[w_sel.a]   <= r_map[w_sel.b];
                r_map[w_sel.b]   <= r_map[w_sel.a];
            end
        end
    end

endmodule
